if_id_pipe: RTL and testbench
=============================

IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the PC and instruction width.
REQ-002 The block SHALL have parameter NOP_INST, default 32'h0000_0000, giving the instruction value presented when id_valid is 0.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_valid  input  1  fetch stage offers if_pc/if_inst this cycle.
REQ-006 if_ready  output  1  block can accept a fetch word this cycle.
REQ-007 if_pc  input  DATA_W  PC of the offered instruction.
REQ-008 if_inst  input  DATA_W  offered instruction word.
REQ-009 flush  input  1  discard all held and incoming instructions (branch redirect).
REQ-010 id_valid  output  1  id_pc/id_inst hold a live instruction.
REQ-011 id_ready  input  1  decode stage consumes the instruction this cycle.
REQ-012 id_pc  output  DATA_W  PC delivered to decode.
REQ-013 id_inst  output  DATA_W  instruction delivered to decode.

Function
REQ-014 A fetch transfer SHALL occur when if_valid and if_ready are both 1; a decode transfer SHALL occur when id_valid and id_ready are both 1.
REQ-015 Latency SHALL be one cycle: a word accepted at edge N appears on id_* with id_valid=1 after edge N, provided the output register is empty or draining.
REQ-016 Order SHALL be preserved; no word is dropped or duplicated except by flush.
REQ-017 While id_valid=1 and id_ready=0, id_pc and id_inst SHALL hold stable.
REQ-018 When id_valid=0, id_pc SHALL equal 0 and id_inst SHALL equal NOP_INST.
REQ-019 A cycle with flush=1 SHALL empty all storage at the next edge (id_valid=0, outputs per REQ-018) and SHALL discard any fetch transfer in the same cycle; flush has priority over every other event.
REQ-020 A decode transfer and a fetch transfer in the same cycle SHALL replace the output word without a bubble.
REQ-021 if_ready SHALL be 0 while rst=1 and SHALL NOT depend combinationally on if_valid.

Reset
REQ-022 On a clk edge with rst=1 the block SHALL clear all storage: id_valid=0, id_pc=0, id_inst=NOP_INST, skid empty; rst overrides flush and all transfers, including mid-stall.
REQ-023 The first cycle after rst deasserts SHALL have if_ready=1.

Configuration
REQ-024 With macro IF_ID_SKID_EN defined, the block SHALL contain a second (skid) register; if_ready SHALL be a registered signal equal to "skid empty"; a word arriving while the output is held goes to the skid, and moves to the output on the next decode transfer; full throughput is sustained with if_ready free of any combinational path from id_ready.
REQ-025 Without IF_ID_SKID_EN, the block SHALL have one register and if_ready = !id_valid || id_ready (combinational from id_ready); all other requirements SHALL hold unchanged.

Structure
REQ-026 DATA_W default, NOP_INST default and a pipe-entry struct (pc, inst) SHALL live in shared package pipe_pkg alongside the existing RegBus/ZeroWord definitions.
REQ-027 The skid storage SHALL be a sub-module if_id_skid (one entry, valid/ready both sides), instantiated only under IF_ID_SKID_EN.

Verification
REQ-028 Reset: rst=1 for 2 cycles with if_valid=1, if_pc=0x100 -> id_valid=0, id_inst=NOP_INST, if_ready=0; after release if_ready=1.
REQ-029 Streaming: id_ready=1, 4 words pc 0x0,0x4,0x8,0xC back-to-back -> same pcs on id_pc on consecutive cycles, one-cycle latency, no bubbles.
REQ-030 Stall: hold id_ready=0 after 0x0 is on output, offer 0x4,0x8 -> SKID_EN: 0x4 in skid, if_ready=0 next cycle, 0x8 waits; id_pc stays 0x0; release -> 0x4, 0x8 delivered in order. Non-SKID: if_ready=0 immediately.
REQ-031 Flush: with 0x20 on output and 0x24 in skid, flush=1 while if_valid=1 with 0x28 -> next cycle id_valid=0, id_pc=0; 0x28 never appears; next offered 0x80 delivered next.
REQ-032 Simultaneous rst and flush with id_ready=0 -> reset state per REQ-022; if_ready=0 in the rst cycle.
REQ-033 Random valid/ready with flush at 5% for 10k cycles under both macro settings -> scoreboard: delivered sequence equals accepted sequence minus flushed words.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-bus width, zero word, IF/ID defaults
// and the pipe-entry payload (pc, inst) carried between fetch and decode.
package pipe_pkg;

  localparam int unsigned REG_BUS_W = 32;
  typedef logic [REG_BUS_W-1:0] RegBus;
  localparam RegBus ZeroWord = '0;

  // IF/ID register defaults
  localparam int unsigned         DATA_W_DEF   = 32;
  localparam logic [DATA_W_DEF-1:0] NOP_INST_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] inst;
  } pipe_entry_t;

endpackage

// File: rtl/if_id_pipe_if.sv
// IF/ID handshake bundle.
//   fetch side : if_valid, if_ready, if_pc, if_inst, flush
//   decode side: id_valid, id_ready, id_pc, id_inst
// master = the environment (fetch + decode stages), slave = the pipe register.
interface if_id_pipe_if
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_pc;
  logic [DATA_W-1:0] if_inst;
  logic              flush;
  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_inst;

  modport master (
    output if_valid, if_pc, if_inst, flush, id_ready,
    input  if_ready, id_valid, id_pc, id_inst
  );

  modport slave (
    input  if_valid, if_pc, if_inst, flush, id_ready,
    output if_ready, id_valid, id_pc, id_inst
  );

endinterface

// File: rtl/if_id_skid.sv
// One-entry skid buffer with valid/ready on both sides.
//   clk, rst       : clock, synchronous active-high reset
//   flush_i        : drop the held entry (highest priority after rst)
//   in_valid_i/in_ready_o/in_data_i    : write side, in_ready_o is registered
//   out_valid_o/out_ready_i/out_data_o : read side
module if_id_skid #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  // Push only when empty and pop only when full, so push and pop never coincide.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (flush_i) begin
      full_d = 1'b0;
      data_d = '0;
    end else if (in_valid_i && !full_q) begin
      full_d = 1'b1;
      data_d = in_data_i;
    end else if (out_ready_i && full_q) begin
      full_d = 1'b0;
      data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign in_ready_o  = !full_q;
  assign out_valid_o = full_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with valid/ready handshake and flush.
//   clk, rst : clock, synchronous active-high reset
//   bus      : if_id_pipe_if.slave (fetch offer, flush, decode delivery)
// Build option IF_ID_SKID_EN: adds a one-entry skid so if_ready is a register
// (skid empty) with no combinational path from id_ready. Without it, a single
// register and if_ready = !id_valid || id_ready.
module if_id_pipe
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEF)
) (
  input  logic        clk,
  input  logic        rst,
  if_id_pipe_if.slave bus
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;

  logic              drain_c;
  logic              fetch_c;
  logic              if_ready_c;
  logic              src_valid_c;
  logic [DATA_W-1:0] src_pc_c;
  logic [DATA_W-1:0] src_inst_c;

  // Output register can take a new word when empty or being consumed.
  assign drain_c = !valid_q || bus.id_ready;
  assign fetch_c = bus.if_valid && if_ready_c;

`ifdef IF_ID_SKID_EN
  localparam int unsigned ENTRY_W = 2 * DATA_W;

  logic               skid_in_ready;
  logic               skid_out_valid;
  logic [ENTRY_W-1:0] skid_out_data;

  // A fetch that cannot enter the stalled output register parks in the skid.
  if_id_skid #(
    .W (ENTRY_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (bus.flush),
    .in_valid_i  (fetch_c && !drain_c),
    .in_ready_o  (skid_in_ready),
    .in_data_i   ({bus.if_pc, bus.if_inst}),
    .out_valid_o (skid_out_valid),
    .out_ready_i (drain_c),
    .out_data_o  (skid_out_data)
  );

  assign if_ready_c  = skid_in_ready && !rst;
  // The skid holds the older word, so it refills the output first.
  assign src_valid_c = skid_out_valid || fetch_c;
  assign {src_pc_c, src_inst_c} = skid_out_valid ? skid_out_data
                                                 : {bus.if_pc, bus.if_inst};
`else
  assign if_ready_c  = !rst && drain_c;
  assign src_valid_c = fetch_c;
  assign src_pc_c    = bus.if_pc;
  assign src_inst_c  = bus.if_inst;
`endif

  // Output register next state; flush wins, empty slots read as pc=0/NOP.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      pc_d    = '0;
      inst_d  = NOP_INST;
    end else if (drain_c) begin
      if (src_valid_c) begin
        valid_d = 1'b1;
        pc_d    = src_pc_c;
        inst_d  = src_inst_c;
      end else begin
        valid_d = 1'b0;
        pc_d    = '0;
        inst_d  = NOP_INST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign bus.if_ready = if_ready_c;
  assign bus.id_valid = valid_q;
  assign bus.id_pc    = pc_q;
  assign bus.id_inst  = inst_q;

endmodule

// File: tb/tb_if_id_pipe.sv
// Self-checking bench for if_id_pipe: directed scenarios plus random
// valid/ready/flush traffic checked by a queue-based scoreboard.
module tb_if_id_pipe;
  import pipe_pkg::*;

  localparam int unsigned     DW  = DATA_W_DEF;
  localparam logic [DW-1:0]   NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_pipe_if #(.DATA_W(DW)) bus ();

  if_id_pipe #(
    .DATA_W   (DW),
    .NOP_INST (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc);
    bus.if_valid = 1'b1;
    bus.if_pc    = pc;
    bus.if_inst  = $urandom;
  endtask

  // Scoreboard: words accepted but not yet consumed, oldest first.
  pipe_entry_t sb[$];

  initial begin
    logic fetch;
    logic dec;
    logic exp_rdy;
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("occupancy", 32'(bus.id_valid), 32'(sb.size() != 0));
      if (bus.id_valid && sb.size() != 0) begin
        check("head_pc", bus.id_pc, sb[0].pc);
        check("head_inst", bus.id_inst, sb[0].inst);
      end
      if (!bus.id_valid) begin
        check("idle_pc", bus.id_pc, 32'd0);
        check("idle_inst", bus.id_inst, NOP);
      end
`ifdef IF_ID_SKID_EN
      exp_rdy = !rst && (sb.size() < 2);
`else
      exp_rdy = !rst && (sb.size() == 0 || bus.id_ready);
`endif
      check("if_ready", 32'(bus.if_ready), 32'(exp_rdy));
      dec   = bus.id_valid && bus.id_ready;
      fetch = bus.if_valid && bus.if_ready;
      if (rst || bus.flush) begin
        sb.delete();
      end else begin
        if (dec && sb.size() != 0) void'(sb.pop_front());
        if (fetch) sb.push_back('{pc: bus.if_pc, inst: bus.if_inst});
      end
    end
  end

  initial begin
    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.id_ready = 1'b0;
    offer(32'h100);

    // Reset with a live fetch offer
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_if_ready", 32'(bus.if_ready), 32'd0);
      check("rst_id_valid", 32'(bus.id_valid), 32'd0);
      check("rst_id_inst", bus.id_inst, NOP);
    end
    rst          = 1'b0;
    bus.if_valid = 1'b0;
    #1;
    check("post_rst_if_ready", 32'(bus.if_ready), 32'd1);

    // Streaming, one-cycle latency, no bubbles
    bus.id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(32'(4 * i));
      step();
      check("stream_valid", 32'(bus.id_valid), 32'd1);
      check("stream_pc", bus.id_pc, 32'(4 * i));
    end
    bus.if_valid = 1'b0;
    step();
    check("stream_drained", 32'(bus.id_valid), 32'd0);

    // Stall with 0x0 held on the output
    offer(32'h0);
    step();
    bus.id_ready = 1'b0;
    offer(32'h4);
    #1;
`ifdef IF_ID_SKID_EN
    check("stall_rdy_skid_free", 32'(bus.if_ready), 32'd1);
    step();
    check("stall_pc_hold0", bus.id_pc, 32'h0);
    check("stall_rdy_skid_full", 32'(bus.if_ready), 32'd0);
    offer(32'h8);
    step();
    check("stall_pc_hold1", bus.id_pc, 32'h0);
    check("stall_rdy_wait", 32'(bus.if_ready), 32'd0);
    bus.id_ready = 1'b1;
    step();
    check("release_pc4", bus.id_pc, 32'h4);
    check("release_rdy", 32'(bus.if_ready), 32'd1);
    step();
    check("release_pc8", bus.id_pc, 32'h8);
`else
    check("stall_rdy", 32'(bus.if_ready), 32'd0);
    step();
    check("stall_pc_hold", bus.id_pc, 32'h0);
    bus.id_ready = 1'b1;
    #1;
    check("release_rdy", 32'(bus.if_ready), 32'd1);
    step();
    check("release_pc4", bus.id_pc, 32'h4);
    offer(32'h8);
    step();
    check("release_pc8", bus.id_pc, 32'h8);
`endif
    bus.if_valid = 1'b0;
    step();
    check("stall_drained", 32'(bus.id_valid), 32'd0);

    // Flush with held words and a simultaneous fetch offer
    offer(32'h20);
    step();
`ifdef IF_ID_SKID_EN
    bus.id_ready = 1'b0;
    offer(32'h24);
    step();
    check("flush_setup_pc", bus.id_pc, 32'h20);
`endif
    bus.flush = 1'b1;
    offer(32'h28);
    step();
    check("flush_valid", 32'(bus.id_valid), 32'd0);
    check("flush_pc", bus.id_pc, 32'd0);
    check("flush_inst", bus.id_inst, NOP);
    bus.flush    = 1'b0;
    bus.id_ready = 1'b1;
    offer(32'h80);
    step();
    check("flush_next_valid", 32'(bus.id_valid), 32'd1);
    check("flush_next_pc", bus.id_pc, 32'h80);
    bus.if_valid = 1'b0;
    step();
    check("flush_drained", 32'(bus.id_valid), 32'd0);

    // rst and flush together during a stall
    offer(32'h40);
    step();
    bus.id_ready = 1'b0;
    offer(32'h44);
    step();
    rst       = 1'b1;
    bus.flush = 1'b1;
    #1;
    check("rstflush_if_ready", 32'(bus.if_ready), 32'd0);
    step();
    check("rstflush_valid", 32'(bus.id_valid), 32'd0);
    check("rstflush_pc", bus.id_pc, 32'd0);
    check("rstflush_inst", bus.id_inst, NOP);
    rst          = 1'b0;
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    #1;
    check("rstflush_rdy_after", 32'(bus.if_ready), 32'd1);
    bus.id_ready = 1'b1;
    step();
    check("rstflush_skid_empty", 32'(bus.id_valid), 32'd0);

    // Random traffic; the monitor scoreboard checks every cycle
    for (int i = 0; i < 10000; i++) begin
      bus.if_valid = ($urandom_range(99) < 65);
      bus.if_pc    = 32'(i * 4);
      bus.if_inst  = $urandom;
      bus.id_ready = ($urandom_range(99) < 60);
      bus.flush    = ($urandom_range(99) < 5);
      step();
    end

    bus.if_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.id_ready = 1'b1;
    repeat (4) step();
    check("final_empty", 32'(bus.id_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
